ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the CPU's single-port word RAM. It shares one RAM between requester 0 (instruction fetch) and requester 1 (load/store unit), with round-robin arbitration and optional locked bursts. It converts byte addresses to word indices and returns read data one cycle after grant. It sits between the core's bus masters and the RAM, which has an asynchronous read and a byte-masked synchronous write.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/rr_pick2.sv | 18 +
 rtl/ram_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, requester indices and
// the byte-to-word address shift.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam int REQ_IF     = 0;
    localparam int REQ_LS     = 1;
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win last
// time is granted. The pointer register itself lives in the caller.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       lg,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = lg ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port word RAM between instruction fetch (m0) and the
// load/store unit (m1): round-robin grants, locked bursts, 1-cycle response.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int MAXBURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [MW-1:0] m0_sel,
    input  logic          m0_we,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [MW-1:0] m1_sel,
    input  logic          m1_we,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [MW-1:0] ram_sel,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam int            BW   = $clog2(MAXBURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAXBURST);

    arb_state_t    state, state_nx;
    logic [BW-1:0] bcnt, bcnt_nx;
    logic          lg;
    logic [1:0]    req, pick, gnt;
    logic          own_hold, gnt_any, gnt_idx, gnt_lock;
    logic          rpend, rsel;
    logic [DW-1:0] rdata_q;

    // Nothing is granted while reset is held.
    assign req[REQ_IF] = m0_req & ~rst;
    assign req[REQ_LS] = m1_req & ~rst;

    rr_pick2 u_pick (
        .req (req),
        .lg  (lg),
        .gnt (pick)
    );

    always_comb begin
        own_hold = 1'b0;
        gnt      = pick;
        state_nx = ST_IDLE;
        bcnt_nx  = '0;
        if (state == ST_OWN0) begin
            own_hold = req[REQ_IF] && m0_lock && (bcnt < BMAX);
        end else if (state == ST_OWN1) begin
            own_hold = req[REQ_LS] && m1_lock && (bcnt < BMAX);
        end
        // A released or exhausted owner falls straight through to round-robin.
        if (own_hold) begin
            gnt = (state == ST_OWN1) ? 2'b10 : 2'b01;
        end
        gnt_any  = |gnt;
        gnt_idx  = gnt[REQ_LS];
        gnt_lock = gnt_idx ? m1_lock : m0_lock;
        if (gnt_any && gnt_lock) begin
            state_nx = gnt_idx ? ST_OWN1 : ST_OWN0;
            bcnt_nx  = own_hold ? bcnt + BW'(1) : BW'(1);
        end
    end

    assign m0_gnt = gnt[REQ_IF];
    assign m1_gnt = gnt[REQ_LS];

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_sel   = '0;
        ram_we    = 1'b0;
        if (gnt[REQ_IF]) begin
            ram_addr  = m0_addr >> WORD_SHIFT;
            ram_wdata = m0_wdata;
            ram_sel   = m0_sel;
            ram_we    = m0_we;
        end else if (gnt[REQ_LS]) begin
            ram_addr  = m1_addr >> WORD_SHIFT;
            ram_wdata = m1_wdata;
            ram_sel   = m1_sel;
            ram_we    = m1_we;
        end
    end

    // lg starts at 1 so fetch wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bcnt    <= '0;
            lg      <= 1'b1;
            rpend   <= 1'b0;
            rsel    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            bcnt    <= bcnt_nx;
            rpend   <= gnt_any;
            rdata_q <= (gnt_any && !ram_we) ? ram_rdata : '0;
            if (gnt_any) begin
                lg   <= gnt_idx;
                rsel <= gnt_idx;
            end
        end
    end

    assign m0_rvalid = rpend && (rsel == 1'(REQ_IF)) && !rst;
    assign m1_rvalid = rpend && (rsel == 1'(REQ_LS)) && !rst;
    assign m0_rdata  = m0_rvalid ? rdata_q : '0;
    assign m1_rdata  = m1_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a burst/round-robin model with its own golden memory.
module tb_ram_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MW   = 4;
    localparam int MAXB = 8;

    typedef struct packed {
        logic        req;
        logic        lock;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } port_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [MW-1:0] m0_sel;
    logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [MW-1:0] m1_sel;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [MW-1:0] ram_sel;
    logic          ram_we;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .MW(MW), .MAXBURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_sel(m0_sel), .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_sel(m1_sel), .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_sel(ram_sel), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    // RAM behind the arbiter: asynchronous read, byte-masked synchronous write.
    logic [31:0] env_mem [0:255];
    assign ram_rdata = env_mem[ram_addr[7:0]];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (ram_sel[b]) env_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state: current burst owner and its grant count, last winner,
    // pending response and a golden copy of memory.
    int          m_owner = -1;
    int          m_run   = 0;
    int          m_last  = 1;
    bit          m_pend  = 0;
    int          m_pidx  = 0;
    logic [31:0] m_pdata = '0;
    logic [31:0] gold [0:255];
    int          exp_g   = -1;

    function automatic logic f_req(input int i);  return (i == 0) ? m0_req  : m1_req;  endfunction
    function automatic logic f_lock(input int i); return (i == 0) ? m0_lock : m1_lock; endfunction
    function automatic logic f_we(input int i);   return (i == 0) ? m0_we   : m1_we;   endfunction
    function automatic logic [31:0] f_addr(input int i);  return (i == 0) ? m0_addr  : m1_addr;  endfunction
    function automatic logic [31:0] f_wdata(input int i); return (i == 0) ? m0_wdata : m1_wdata; endfunction
    function automatic logic [3:0]  f_sel(input int i);   return (i == 0) ? m0_sel   : m1_sel;   endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        int          g;
        logic [31:0] ea;
        g = -1;
        if (!rst) begin
            if (m_owner >= 0 && f_req(m_owner) && f_lock(m_owner) && m_run < MAXB) g = m_owner;
            else if (m0_req && m1_req) g = (m_last == 0) ? 1 : 0;
            else if (m0_req) g = 0;
            else if (m1_req) g = 1;
        end
        exp_g = g;
        ea = (g >= 0) ? (f_addr(g) >> 2) : 32'h0;
        checkOutput("m0_gnt", m0_gnt, g == 0);
        checkOutput("m1_gnt", m1_gnt, g == 1);
        checkOutput("ram_addr", ram_addr, ea);
        checkOutput("ram_we", ram_we, (g >= 0) ? f_we(g) : 1'b0);
        checkOutput("ram_sel", ram_sel, (g >= 0) ? f_sel(g) : 4'h0);
        checkOutput("ram_wdata", ram_wdata, (g >= 0) ? f_wdata(g) : 32'h0);
        checkOutput("m0_rvalid", m0_rvalid, m_pend && m_pidx == 0 && !rst);
        checkOutput("m1_rvalid", m1_rvalid, m_pend && m_pidx == 1 && !rst);
        checkOutput("m0_rdata", m0_rdata, (m_pend && m_pidx == 0 && !rst) ? m_pdata : 32'h0);
        checkOutput("m1_rdata", m1_rdata, (m_pend && m_pidx == 1 && !rst) ? m_pdata : 32'h0);
    end

    always @(posedge clk) begin : mdl
        int          g, w;
        logic [31:0] wd;
        logic [3:0]  sm;
        g = exp_g;
        if (rst) begin
            m_owner = -1; m_run = 0; m_last = 1; m_pend = 0;
        end else if (g >= 0) begin
            w = int'((f_addr(g) >> 2) % 256);
            m_pend  = 1;
            m_pidx  = g;
            m_pdata = f_we(g) ? 32'h0 : gold[w];
            if (f_lock(g)) begin
                m_run   = (m_owner == g && m_run < MAXB) ? m_run + 1 : 1;
                m_owner = g;
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
            m_last = g;
            if (f_we(g)) begin
                wd = f_wdata(g);
                sm = f_sel(g);
                for (int b = 0; b < 4; b++) if (sm[b]) gold[w][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            m_owner = -1; m_run = 0; m_pend = 0;
        end
    end

    function automatic port_t rd(input logic [31:0] a, input logic lk = 1'b0);
        port_t p;
        p = '0; p.req = 1'b1; p.lock = lk; p.addr = a; p.sel = 4'hF;
        return p;
    endfunction

    function automatic port_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        port_t p;
        p = '0; p.req = 1'b1; p.we = 1'b1; p.addr = a; p.wdata = d; p.sel = s;
        return p;
    endfunction

    task automatic applyStimulus(input logic r, input port_t p0, input port_t p1);
        @(posedge clk); #1;
        rst = r;
        m0_req = p0.req; m0_lock = p0.lock; m0_we = p0.we; m0_addr = p0.addr; m0_wdata = p0.wdata; m0_sel = p0.sel;
        m1_req = p1.req; m1_lock = p1.lock; m1_we = p1.we; m1_addr = p1.addr; m1_wdata = p1.wdata; m1_sel = p1.sel;
    endtask

    function automatic port_t rand_port();
        port_t p;
        p.req   = ($urandom_range(0, 99) < 85);
        p.lock  = ($urandom_range(0, 99) < 80);
        p.we    = 1'($urandom_range(0, 1));
        p.addr  = 32'($urandom_range(0, 255));
        p.wdata = $urandom;
        p.sel   = 4'($urandom_range(0, 15));
        return p;
    endfunction

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        port_t idle, p0, p1;
        int    seq[$];
        int    n0, exp3[10];
        logic [1:0] exp4[4];
        idle = '0;
        rst = 1'b1;
        {m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_sel} = '0;
        {m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_sel} = '0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'h1000_0000 + i;
            gold[i]    = 32'h1000_0000 + i;
        end

        applyStimulus(1'b1, idle, idle);
        applyStimulus(1'b1, idle, idle);
        @(negedge clk);
        checkOutput("reset_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        checkOutput("reset_rdata", {m1_rdata, m0_rdata}, 64'h0);

        // Alternating reads: tie goes to m0 first after reset.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, rd(32'h10), rd(32'h20));
            @(negedge clk);
            checkOutput("alt_gnt", {m1_gnt, m0_gnt}, (i % 2) ? 2'b10 : 2'b01);
            checkOutput("alt_addr", ram_addr, (i % 2) ? 32'h8 : 32'h4);
            if (i > 0) begin
                checkOutput("alt_rvalid", {m1_rvalid, m0_rvalid}, (i % 2) ? 2'b01 : 2'b10);
                checkOutput("alt_rdata", (i % 2) ? m0_rdata : m1_rdata,
                            (i % 2) ? 32'h1000_0004 : 32'h1000_0008);
            end
        end

        // Partial write then read-back of the same word.
        applyStimulus(1'b0, idle, wr(32'h40, 32'hDEAD_BEEF, 4'b0011));
        @(negedge clk);
        checkOutput("wr_gnt", {m1_gnt, ram_we, ram_sel, ram_addr}, {1'b1, 1'b1, 4'b0011, 32'h10});
        applyStimulus(1'b0, rd(32'h40), idle);
        @(negedge clk);
        checkOutput("wr_ack", {m0_gnt, m1_rvalid, m1_rdata}, {1'b1, 1'b1, 32'h0});
        applyStimulus(1'b0, idle, idle);
        @(negedge clk);
        checkOutput("rb_data", {m0_rvalid, m0_rdata}, {1'b1, 32'h1000_BEEF});

        // Locked m0 burst of 12 against continuous m1 requests.
        applyStimulus(1'b1, idle, idle);
        exp3 = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        n0 = 0;
        for (int c = 0; c < 30 && n0 < 12; c++) begin
            p0 = (n0 < 12) ? rd(32'h80 + 32'(4 * n0), 1'b1) : idle;
            applyStimulus(1'b0, p0, rd(32'h24));
            @(negedge clk);
            if (m0_gnt) begin seq.push_back(0); n0++; end
            if (m1_gnt) seq.push_back(1);
        end
        checkOutput("burst_m0_count", 64'(n0), 64'd12);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("burst_seq%0d", k), 64'((k < seq.size()) ? seq[k] : -1), 64'(exp3[k]));
        end

        // m1 lock drops on its third access: m0 takes that cycle.
        applyStimulus(1'b1, idle, idle);
        exp4 = '{2'b10, 2'b10, 2'b01, 2'b10};
        for (int c = 0; c < 4; c++) begin
            p0 = (c == 1 || c == 2) ? rd(32'h34) : idle;
            p1 = (c < 2) ? rd(32'h30, 1'b1) : rd(32'h38);
            applyStimulus(1'b0, p0, p1);
            @(negedge clk);
            checkOutput($sformatf("release_gnt%0d", c), {m1_gnt, m0_gnt}, exp4[c]);
        end

        // Reset right after an m0 grant drops the pending response.
        applyStimulus(1'b0, rd(32'h44), idle);
        @(negedge clk);
        checkOutput("rst_pre_gnt", m0_gnt, 1'b1);
        applyStimulus(1'b1, idle, rd(32'h48));
        @(negedge clk);
        checkOutput("rst_drop", {m0_rvalid, m1_gnt}, 2'b00);
        applyStimulus(1'b0, rd(32'h44), rd(32'h48));
        @(negedge clk);
        checkOutput("rst_post", {m1_gnt, m0_gnt, m0_rvalid}, 3'b010);

        applyStimulus(1'b0, idle, idle);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, idle, idle);
            @(negedge clk);
            checkOutput("idle_quiet", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, ram_we, ram_sel}, '0);
        end

        // Random traffic; a request is held until the model says it was granted.
        p0 = idle; p1 = idle;
        for (int c = 0; c < 3000; c++) begin
            if (!(p0.req && exp_g != 0)) p0 = rand_port();
            if (!(p1.req && exp_g != 1)) p1 = rand_port();
            applyStimulus(($urandom_range(0, 299) == 0), p0, p1);
        end
        applyStimulus(1'b0, idle, idle);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
